stack_mem_ctrl: RTL and testbench

- Initiator/sequencer for the 8-bit data memory of the RNBIP-2 core.
- Accepts one memory operation at a time from the control unit: PUSH, POP, CALL, RET, LOAD or STORE.
- Owns the stack pointer and drives the memory strobes and select lines (rd, wr, s2, s5).
- Captures read data for register writeback or PC reload, and flags stack overflow/underflow.

---
 rtl/rnbip_pkg.sv | 54 +++++
 rtl/sp_unit.sv | 44 ++++
 rtl/stack_mem_ctrl.sv | 134 +++++++++++++
 tb/tb_stack_mem_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rnbip_pkg.sv
// rtl/rnbip_pkg.sv - shared op/state encodings and defaults for the RNBIP-2 data memory path
package rnbip_pkg;

    typedef enum logic [2:0] {
        OP_PUSH  = 3'd0,
        OP_POP   = 3'd1,
        OP_CALL  = 3'd2,
        OP_RET   = 3'd3,
        OP_LOAD  = 3'd4,
        OP_STORE = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADJ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int         DW_DEFAULT       = 8;
    localparam logic [7:0] SP_BASE_DEFAULT  = 8'hFF;
    localparam logic [7:0] SP_LIMIT_DEFAULT = 8'hC0;

    typedef struct packed {
        logic rd;
        logic wr;
        logic s2;
        logic s5;
    } xfer_ctrl_t;

    function automatic logic is_push(input logic [2:0] op);
        return (op == OP_PUSH) || (op == OP_CALL);
    endfunction

    function automatic logic is_pop(input logic [2:0] op);
        return (op == OP_POP) || (op == OP_RET);
    endfunction

    // Strobe/select pattern driven during the single XFER cycle of each op.
    function automatic xfer_ctrl_t xfer_ctrl(input logic [2:0] op);
        xfer_ctrl_t c;
        c = '0;
        case (op)
            OP_PUSH:         c = 4'b0111;
            OP_CALL:         c = 4'b0110;
            OP_POP, OP_RET:  c = 4'b1010;
            OP_LOAD:         c = 4'b1000;
            OP_STORE:        c = 4'b0101;
            default:         c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sp_unit.sv
// rtl/sp_unit.sv - stack pointer register with inc/dec enables and full/empty flags
module sp_unit
    import rnbip_pkg::*;
#(
    parameter int            DW       = DW_DEFAULT,
    parameter logic [DW-1:0] SP_BASE  = DW'(SP_BASE_DEFAULT),
    parameter logic [DW-1:0] SP_LIMIT = DW'(SP_LIMIT_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [DW-1:0] sp,
    output logic          full,
    output logic          empty
);

    localparam logic [DW-1:0] FULL_SP = SP_LIMIT - 1'b1;

    logic [DW-1:0] sp_q;
    logic [DW-1:0] sp_d;

    always_comb begin
        sp_d = sp_q;
        if (inc) begin
            sp_d = sp_q + 1'b1;
        end else if (dec) begin
            sp_d = sp_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= SP_BASE;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp    = sp_q;
    assign full  = (sp_q == FULL_SP);
    assign empty = (sp_q == SP_BASE);

endmodule

// File: rtl/stack_mem_ctrl.sv
// rtl/stack_mem_ctrl.sv - sequencer for stack and load/store accesses to the 8-bit data memory
module stack_mem_ctrl
    import rnbip_pkg::*;
#(
    parameter int            DW       = DW_DEFAULT,
    parameter logic [DW-1:0] SP_BASE  = DW'(SP_BASE_DEFAULT),
    parameter logic [DW-1:0] SP_LIMIT = DW'(SP_LIMIT_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    op,
    output logic [DW-1:0] sp_out,
    input  logic [DW-1:0] mem_rdata,
    output logic          rd,
    output logic          wr,
    output logic          s2,
    output logic          s5,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          rf_we,
    output logic          pc_load
);

    state_e        state_q;
    logic [2:0]    op_q;
    xfer_ctrl_t    ctrl_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          rf_we_q;
    logic          pc_load_q;
    logic [DW-1:0] rdata_q;

    logic sp_inc;
    logic sp_dec;
    logic sp_full;
    logic sp_empty;
    logic fault;

    // Pop-type ops pre-increment in ADJ; push-type ops post-decrement on the XFER closing edge.
    assign sp_inc = (state_q == ADJ);
    assign sp_dec = (state_q == XFER) && is_push(op_q);

    assign fault = (op > 3'd5)
                || (is_push(op) && sp_full)
                || (is_pop(op) && sp_empty);

    sp_unit #(
        .DW       (DW),
        .SP_BASE  (SP_BASE),
        .SP_LIMIT (SP_LIMIT)
    ) u_sp (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sp_inc),
        .dec   (sp_dec),
        .sp    (sp_out),
        .full  (sp_full),
        .empty (sp_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            ctrl_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rf_we_q   <= 1'b0;
            pc_load_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        busy_q <= 1'b1;
                        if (fault) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (is_pop(op)) begin
                            state_q <= ADJ;
                        end else begin
                            state_q <= XFER;
                            ctrl_q  <= xfer_ctrl(op);
                        end
                    end
                end
                ADJ: begin
                    state_q <= XFER;
                    ctrl_q  <= xfer_ctrl(op_q);
                end
                XFER: begin
                    ctrl_q <= '0;
                    if (ctrl_q.rd) begin
                        rdata_q <= mem_rdata;
                    end
                    state_q   <= DONE;
                    done_q    <= 1'b1;
                    rf_we_q   <= (op_q == OP_POP) || (op_q == OP_LOAD);
                    pc_load_q <= (op_q == OP_RET);
                end
                DONE: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    err_q     <= 1'b0;
                    rf_we_q   <= 1'b0;
                    pc_load_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd      = ctrl_q.rd;
    assign wr      = ctrl_q.wr;
    assign s2      = ctrl_q.s2;
    assign s5      = ctrl_q.s5;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rf_we   = rf_we_q;
    assign pc_load = pc_load_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// tb/tb_stack_mem_ctrl.sv - directed and random checks of stack_mem_ctrl against a behavioural model
module tb_stack_mem_ctrl;
    import rnbip_pkg::*;

    localparam logic [7:0] SP_BASE  = 8'hFF;
    localparam logic [7:0] SP_LIMIT = 8'hC0;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic [2:0] op       = 3'd0;
    logic [7:0] sp_out;
    logic [7:0] mem_rdata;
    logic       rd, wr, s2, s5, busy, done, err, rf_we, pc_load;
    logic [7:0] rdata;

    logic [7:0] r0       = 8'h00;
    logic [7:0] rn       = 8'h00;
    logic [7:0] npc      = 8'h00;
    logic       mem_init = 1'b0;
    logic [7:0] mem [256];
    int         wr_count = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] ref_sp;
    logic [7:0] ref_rdata;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    stack_mem_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .sp_out    (sp_out),
        .mem_rdata (mem_rdata),
        .rd        (rd),
        .wr        (wr),
        .s2        (s2),
        .s5        (s5),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .rf_we     (rf_we),
        .pc_load   (pc_load)
    );

    assign mem_rdata = mem[s2 ? sp_out : r0];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
        end else if (wr) begin
            mem[s2 ? sp_out : r0] <= s5 ? rn : npc;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [7:0] r0v, input logic [7:0] rnv,
                         input logic [7:0] npcv, input bit spam);
        bit         fault;
        bit         writes;
        int         lat;
        int         wc0;
        logic [3:0] xs;
        logic [7:0] xfer_sp;
        logic [7:0] waddr;

        fault = (o > 3'd5)
             || ((o == OP_PUSH || o == OP_CALL) && ref_sp == SP_LIMIT - 8'd1)
             || ((o == OP_POP  || o == OP_RET)  && ref_sp == SP_BASE);
        lat     = fault ? 1 : ((o == OP_POP || o == OP_RET) ? 3 : 2);
        xfer_sp = (o == OP_POP || o == OP_RET) ? ref_sp + 8'd1 : ref_sp;
        case (o)
            OP_PUSH:  xs = 4'b0111;
            OP_CALL:  xs = 4'b0110;
            OP_POP:   xs = 4'b1010;
            OP_RET:   xs = 4'b1010;
            OP_LOAD:  xs = 4'b1000;
            OP_STORE: xs = 4'b0101;
            default:  xs = 4'b0000;
        endcase
        writes = !fault && (o == OP_PUSH || o == OP_CALL || o == OP_STORE);
        waddr  = (o == OP_STORE) ? r0v : ref_sp;

        if (!fault) begin
            case (o)
                OP_PUSH:  begin ref_mem[ref_sp] = rnv;  ref_sp = ref_sp - 8'd1; end
                OP_CALL:  begin ref_mem[ref_sp] = npcv; ref_sp = ref_sp - 8'd1; end
                OP_POP, OP_RET: begin ref_sp = ref_sp + 8'd1; ref_rdata = ref_mem[ref_sp]; end
                OP_LOAD:  ref_rdata = ref_mem[r0v];
                OP_STORE: ref_mem[r0v] = rnv;
                default:  ;
            endcase
        end

        wc0   = wr_count;
        r0    = r0v;
        rn    = rnv;
        npc   = npcv;
        op    = o;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            chk("busy", busy, 1'b1);
            chk("done_timing", done, (k == lat));
            chk("strobes", {rd, wr, s2, s5}, (!fault && k == lat - 1) ? xs : 4'b0000);
            if (!fault && k == lat - 1) chk("xfer_sp", sp_out, xfer_sp);
            if (k == lat) begin
                chk("err", err, fault);
                chk("rf_we", rf_we, !fault && (o == OP_POP || o == OP_LOAD));
                chk("pc_load", pc_load, !fault && o == OP_RET);
                chk("sp_after", sp_out, ref_sp);
                chk("rdata", rdata, ref_rdata);
            end
            if (spam && k == 1) begin
                start = 1'b1;
                op    = 3'($urandom_range(0, 7));
            end
            if (k < lat) begin
                cycle();
                start = 1'b0;
            end
        end
        cycle();
        start = 1'b0;
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("write_count", wr_count - wc0, writes ? 1 : 0);
        if (writes) chk("mem_word", mem[waddr], ref_mem[waddr]);
        if (spam) begin
            cycle();
            chk("spam_not_queued", {busy, done}, 2'b00);
        end
    endtask

    initial begin
        int         wc0;
        logic [7:0] o;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hA5;
        ref_sp    = SP_BASE;
        ref_rdata = 8'h00;

        rst_n    = 1'b0;
        mem_init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sp", sp_out, SP_BASE);
        chk("reset_rdata", rdata, 8'h00);
        chk("reset_flags", {rd, wr, s2, s5, busy, done, err, rf_we, pc_load}, 9'h000);
        @(negedge clk);
        rst_n    = 1'b1;
        mem_init = 1'b0;
        cycle();

        do_op(OP_PUSH,  8'h00, 8'h5A, 8'h00, 1'b0);
        do_op(OP_POP,   8'h00, 8'h00, 8'h00, 1'b0);
        do_op(OP_CALL,  8'h00, 8'h00, 8'h23, 1'b0);
        do_op(OP_RET,   8'h00, 8'h00, 8'h00, 1'b0);
        do_op(OP_POP,   8'h00, 8'h00, 8'h00, 1'b0);
        do_op(OP_RET,   8'h00, 8'h00, 8'h00, 1'b0);
        do_op(OP_STORE, 8'h10, 8'h77, 8'h00, 1'b0);
        do_op(OP_LOAD,  8'h10, 8'h00, 8'h00, 1'b0);
        do_op(3'd6,     8'h00, 8'h00, 8'h00, 1'b0);
        do_op(3'd7,     8'h00, 8'h00, 8'h00, 1'b0);

        // Reset in the middle of the XFER cycle of a PUSH.
        wc0   = wr_count;
        rn    = ~ref_mem[SP_BASE];
        op    = OP_PUSH;
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("pre_reset_wr", wr, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_flags", {rd, wr, s2, s5, busy, done, err, rf_we, pc_load}, 9'h000);
        chk("async_reset_sp", sp_out, SP_BASE);
        chk("async_reset_rdata", rdata, 8'h00);
        cycle();
        chk("abandoned_write", wr_count - wc0, 0);
        chk("abandoned_mem", mem[SP_BASE], ref_mem[SP_BASE]);
        @(negedge clk);
        rst_n     = 1'b1;
        ref_sp    = SP_BASE;
        ref_rdata = 8'h00;
        cycle();

        do_op(OP_PUSH, 8'h00, 8'h3C, 8'h00, 1'b1);
        do_op(OP_POP,  8'h00, 8'h00, 8'h00, 1'b1);
        do_op(OP_POP,  8'h00, 8'h00, 8'h00, 1'b1);

        for (int i = 0; i < 100 && ref_sp != SP_LIMIT - 8'd1; i++) begin
            do_op(OP_PUSH, 8'h00, 8'($urandom), 8'h00, 1'b0);
        end
        chk("full_sp", sp_out, SP_LIMIT - 8'd1);
        do_op(OP_PUSH, 8'h00, 8'hEE, 8'h00, 1'b0);
        do_op(OP_CALL, 8'h00, 8'h00, 8'hEE, 1'b0);
        chk("full_sp_held", sp_out, SP_LIMIT - 8'd1);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 11))
                0, 1:    o = OP_PUSH;
                2, 3:    o = OP_POP;
                4:       o = OP_CALL;
                5, 6:    o = OP_RET;
                7:       o = OP_LOAD;
                8:       o = OP_STORE;
                9:       o = 8'd6;
                10:      o = 8'd7;
                default: o = OP_POP;
            endcase
            do_op(o[2:0], 8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
